// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA1 sender-link arbiter: FSM encoding,
// default parameter values and the sender word-count width.
package fpga_link_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int TIMEOUT_DEF   = 1024;
  localparam int MAX_RETRY_DEF = 3;
  localparam int CNT_W         = 10;
  localparam int RETRY_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CMPL  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// otherwise wraps around to the lowest requester overall.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (ptr <= PW'(gi));
    end
  endgenerate

  assign masked = req & hi_mask;
  assign sel    = (|masked) ? masked : req;
  // Isolate the lowest set bit (two's-complement trick).
  assign gnt    = sel & (~sel + N'(1));

endmodule

// File: rtl/fpga1_link_arbiter.sv
// Shares one FPGA1 sender link among N_REQ requesters: round-robin grant,
// per-attempt timeout with bounded re-issue, done/error completion pulses.
module fpga1_link_arbiter
  import fpga_link_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [CNT_W*N_REQ-1:0] len_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       err_o,
  output logic                   snd_start_o,
  output logic [CNT_W-1:0]       snd_count_o,
  input  logic                   snd_done_i,
  output logic                   busy_o,
  output logic [RETRY_W-1:0]     retry_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [N_REQ-1:0]   done_reg, done_next;
  logic [N_REQ-1:0]   err_reg, err_next;
  logic               start_reg, start_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [TW-1:0]      tmr_reg, tmr_next;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PW-1:0]      ptr_grant;
  logic [CNT_W-1:0]   len_sel;
  logic               timeout_hit;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (req_i),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  // Decode the one-hot winner into its length and the next pointer value.
  always_comb begin
    ptr_grant = '0;
    len_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        ptr_grant = PW'((i + 1) % N_REQ);
        len_sel   = len_i[i*CNT_W +: CNT_W];
      end
    end
  end

  assign timeout_hit = (tmr_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
      start_reg <= 1'b0;
      count_reg <= '0;
      retry_reg <= '0;
      ptr_reg   <= '0;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      start_reg <= start_next;
      count_reg <= count_next;
      retry_reg <= retry_next;
      ptr_reg   <= ptr_next;
      tmr_reg   <= tmr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    err_next   = '0;
    start_next = 1'b0;
    count_next = count_reg;
    retry_next = retry_reg;
    ptr_next   = ptr_reg;
    tmr_next   = tmr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_i) begin
          state_next = ST_START;
          gnt_next   = arb_gnt;
          count_next = len_sel;
          start_next = (len_sel != '0);
          ptr_next   = ptr_grant;
        end
      end
      ST_START: begin
        // Zero-length transfers never touch the sender.
        if (count_reg == '0) begin
          state_next = ST_CMPL;
          done_next  = gnt_reg;
        end else begin
          state_next = ST_WAIT;
          tmr_next   = '0;
        end
      end
      ST_WAIT: begin
        if (tmr_reg != {TW{1'b1}}) begin
          tmr_next = tmr_reg + TW'(1);
        end
        // Completion takes priority over a coincident timeout.
        if (snd_done_i) begin
          state_next = ST_CMPL;
          done_next  = gnt_reg;
        end else if (timeout_hit) begin
          if (retry_reg < RETRY_W'(MAX_RETRY)) begin
            retry_next = retry_reg + RETRY_W'(1);
            state_next = ST_START;
            start_next = 1'b1;
          end else begin
            state_next = ST_CMPL;
            err_next   = gnt_reg;
          end
        end
      end
      ST_CMPL: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        retry_next = '0;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign snd_start_o = start_reg;
  assign snd_count_o = count_reg;
  assign retry_o     = retry_reg;
  assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fpga1_link_arbiter.sv
// Bench for fpga1_link_arbiter: timeline-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fpga1_link_arbiter;

  localparam int N    = 4;
  localparam int T    = 32;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_i;
  logic [39:0] len_i;
  logic        snd_done_i;
  logic [3:0]  gnt_o, done_o, err_o;
  logic        snd_start_o, busy_o;
  logic [9:0]  snd_count_o;
  logic [1:0]  retry_o;

  fpga1_link_arbiter #(.N_REQ(N), .TIMEOUT(T), .MAX_RETRY(MAXR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .len_i       (len_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .snd_start_o (snd_start_o),
    .snd_count_o (snd_count_o),
    .snd_done_i  (snd_done_i),
    .busy_o      (busy_o),
    .retry_o     (retry_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a transfer is a timeline anchored at its grant cycle g;
  // each attempt occupies T+1 cycles (start cycle, then a T-cycle window).
  int         m_owner = -1;
  int         m_g     = 0;
  int         m_len   = 0;
  int         m_ptr   = 0;
  int         m_cmpl  = -1;
  bit         m_err   = 1'b0;
  logic [9:0] m_count = '0;
  logic [3:0] e_gnt = '0, e_done = '0, e_err = '0;
  logic       e_start = 1'b0, e_busy = 1'b0;
  logic [1:0] e_retry = '0;
  logic [9:0] e_count = '0;

  int n_start = 0, n_done = 0, n_err = 0;
  int start_retry[$];
  int order[$];
  logic [3:0] gnt_prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_count = '0;
    m_cmpl  = -1;
    e_gnt = '0; e_done = '0; e_err = '0; e_start = 1'b0;
    e_busy = 1'b0; e_retry = '0; e_count = '0;
  endtask

  task automatic model_step();
    int n, prev, pick, k, off;
    cyc++;
    n = cyc;
    if (m_owner < 0) begin
      if (req_i != 4'd0) begin
        pick = -1;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (pick < 0 && req_i[k]) pick = k;
        end
        m_owner = pick;
        m_g     = n;
        m_len   = int'(len_i[10*pick +: 10]);
        m_count = len_i[10*pick +: 10];
        m_ptr   = (pick + 1) % N;
        m_cmpl  = -1;
      end
    end else if (m_cmpl == n - 1) begin
      m_owner = -1;
    end else begin
      prev = n - 1 - m_g;
      if (m_len == 0) begin
        m_cmpl = n; m_err = 1'b0;
      end else if ((prev % (T + 1)) >= 1 && snd_done_i) begin
        m_cmpl = n; m_err = 1'b0;
      end else if ((prev % (T + 1)) == T && (prev / (T + 1)) == MAXR) begin
        m_cmpl = n; m_err = 1'b1;
      end
    end
    e_gnt = '0; e_done = '0; e_err = '0; e_start = 1'b0;
    e_busy = 1'b0; e_retry = '0; e_count = m_count;
    if (m_owner >= 0) begin
      e_busy = 1'b1;
      e_gnt[m_owner] = 1'b1;
      if (m_cmpl == n) begin
        e_retry = 2'((n - 1 - m_g) / (T + 1));
        if (m_err) e_err = e_gnt;
        else       e_done = e_gnt;
      end else begin
        off = n - m_g;
        e_retry = 2'(off / (T + 1));
        e_start = ((off % (T + 1)) == 0) && (m_len != 0);
      end
    end
  endtask

  task automatic compare_all();
    chk("gnt",    32'(gnt_o),       32'(e_gnt));
    chk("done",   32'(done_o),      32'(e_done));
    chk("err",    32'(err_o),       32'(e_err));
    chk("start",  32'(snd_start_o), 32'(e_start));
    chk("busy",   32'(busy_o),      32'(e_busy));
    chk("retry",  32'(retry_o),     32'(e_retry));
    chk("count",  32'(snd_count_o), 32'(e_count));
    chk("onehot", 32'($onehot0(gnt_o)), 32'd1);
    chk("done_err_excl", 32'((done_o != 4'd0) && (err_o != 4'd0)), 32'd0);
  endtask

  task automatic monitor_step();
    if (snd_start_o) begin
      n_start++;
      start_retry.push_back(int'(retry_o));
    end
    if (done_o != 4'd0) begin
      n_done++;
      $display("xfer gnt=%b len=%0d result=done retry=%0d cycle=%0d", gnt_o, snd_count_o, retry_o, cyc);
    end
    if (err_o != 4'd0) begin
      n_err++;
      $display("xfer gnt=%b len=%0d result=error retry=%0d cycle=%0d", gnt_o, snd_count_o, retry_o, cyc);
    end
    if (gnt_o != 4'd0 && gnt_prev == 4'd0) begin
      for (int i = 0; i < N; i++) if (gnt_o[i]) order.push_back(i);
    end
    gnt_prev <= gnt_o;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      compare_all();
      monitor_step();
    end else begin
      gnt_prev <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt_o),       0);
    chk({tag, "_done"},  32'(done_o),      0);
    chk({tag, "_err"},   32'(err_o),       0);
    chk({tag, "_start"}, 32'(snd_start_o), 0);
    chk({tag, "_busy"},  32'(busy_o),      0);
    chk({tag, "_retry"}, 32'(retry_o),     0);
    chk({tag, "_count"}, 32'(snd_count_o), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_i = '0;
    snd_done_i = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Waits for the next start pulse, then asserts snd_done_i for one cycle
  // placed 'delay' cycles after the start cycle.
  task automatic serve_one(input int delay);
    int w;
    w = 0;
    @(negedge clk);
    while (!snd_start_o && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("start_seen", 32'(snd_start_o), 1);
    repeat (delay) tick();
    snd_done_i = 1'b1;
    tick();
    snd_done_i = 1'b0;
  endtask

  initial begin
    int b_start, b_done, b_err, b_ord, b_q, w;
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};
    req_i = '0;
    len_i = '0;
    snd_done_i = 1'b0;

    // Case 1: single transfer, done 20 cycles after start.
    do_reset();
    len_i = {10'd0, 10'd0, 10'd0, 10'd16};
    req_i = 4'b0001;
    tick();
    req_i = '0;
    #3;
    chk("c1_gnt",   32'(gnt_o), 32'b0001);
    chk("c1_start", 32'(snd_start_o), 1);
    chk("c1_count", 32'(snd_count_o), 16);
    b_start = n_start; b_done = n_done; b_err = n_err;
    serve_one(20);
    #3;
    chk("c1_done", 32'(done_o), 32'b0001);
    chk("c1_err",  32'(err_o), 0);
    repeat (3) tick();
    chk("c1_ndone",  n_done - b_done, 1);
    chk("c1_nerr",   n_err - b_err, 0);
    chk("c1_nstart", n_start - b_start, 1);
    $display("case1 single transfer complete");

    // Case 2: all four requesting, round-robin order from reset pointer.
    do_reset();
    len_i = {4{10'd5}};
    b_ord = order.size();
    req_i = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) serve_one(5);
    req_i = '0;
    repeat (4) tick();
    chk("c2_ngrants", order.size() - b_ord, 5);
    for (int i = 0; i < 5; i++) chk("c2_order", order[b_ord + i], exp_ord[i]);
    $display("case2 round robin complete");

    // Case 3: sender never answers; request withdrawn after grant.
    do_reset();
    len_i = {10'd0, 10'd0, 10'd0, 10'd7};
    req_i = 4'b0001;
    tick();
    req_i = '0;
    b_start = n_start; b_err = n_err; b_q = start_retry.size();
    w = 0;
    @(negedge clk);
    while (err_o == 4'd0 && w < 4 * (T + 1) + 20) begin
      @(negedge clk);
      w++;
    end
    chk("c3_err",   32'(err_o), 32'b0001);
    chk("c3_retry", 32'(retry_o), 3);
    chk("c3_done",  32'(done_o), 0);
    tick();
    #3;
    chk("c3_gnt",  32'(gnt_o), 0);
    chk("c3_busy", 32'(busy_o), 0);
    chk("c3_nstart", n_start - b_start, 4);
    chk("c3_nerr",   n_err - b_err, 1);
    for (int i = 0; i < 4; i++) chk("c3_retry_seq", start_retry[b_q + i], i);
    $display("case3 timeout and error complete");

    // Case 4: zero-length transfer for requester 2.
    do_reset();
    len_i = {10'd0, 10'd0, 10'd0, 10'd3};
    req_i = 4'b0100;
    b_start = n_start;
    tick();
    req_i = '0;
    #3;
    chk("c4_gnt",   32'(gnt_o), 32'b0100);
    chk("c4_start", 32'(snd_start_o), 0);
    tick();
    #3;
    chk("c4_done", 32'(done_o), 32'b0100);
    chk("c4_err",  32'(err_o), 0);
    repeat (2) tick();
    chk("c4_nstart", n_start - b_start, 0);
    $display("case4 zero length complete");

    // Case 5: done lands in the exact timeout cycle of the first attempt.
    do_reset();
    len_i = {10'd0, 10'd0, 10'd0, 10'd9};
    req_i = 4'b0001;
    tick();
    req_i = '0;
    b_start = n_start; b_err = n_err;
    serve_one(T);
    #3;
    chk("c5_done",  32'(done_o), 32'b0001);
    chk("c5_retry", 32'(retry_o), 0);
    repeat (3) tick();
    chk("c5_nstart", n_start - b_start, 1);
    chk("c5_nerr",   n_err - b_err, 0);
    $display("case5 done beats timeout complete");

    // Case 6: asynchronous reset during WAIT, then requester 1 alone.
    do_reset();
    len_i = {10'd0, 10'd0, 10'd4, 10'd9};
    req_i = 4'b0001;
    tick();
    req_i = '0;
    b_done = n_done; b_err = n_err;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("c6");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_i = 4'b0010;
    tick();
    req_i = '0;
    #3;
    chk("c6_gnt",   32'(gnt_o), 32'b0010);
    chk("c6_count", 32'(snd_count_o), 4);
    chk("c6_ndone", n_done - b_done, 0);
    chk("c6_nerr",  n_err - b_err, 0);
    serve_one(3);
    repeat (3) tick();
    $display("case6 async reset complete");

    // Random traffic: alternating high and low completion rates.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req_i = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++)
          len_i[10*k +: 10] = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
      end
      if (((c / 500) % 2) == 1) snd_done_i = ($urandom_range(0, 59) == 0);
      else                      snd_done_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end
    req_i = '0;
    snd_done_i = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
